// File: rtl/rails_pkg.sv
// rtl/rails_pkg.sv - shared constants and FSM encoding for the rails sequencer
package rails_pkg;

  localparam int DEF_DW    = 4;
  localparam int DEF_MAX_N = 15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_SEQ,
    RUN,
    DONE
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/rails_lifo.sv
// rtl/rails_lifo.sv - station stack: synchronous push/pop/clear, combinational top and empty
module rails_lifo #(
  parameter int DEPTH = 15,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_m1;
  logic          full;

  assign sp_m1 = sp - PW'(1);
  assign empty = (sp == '0);
  assign full  = (sp == PW'(DEPTH));
  assign top   = empty ? '0 : mem[sp_m1];

  // Pushed car lands in the slot just above the current top.
  always_ff @(posedge clk) begin
    if (push && !full) mem[sp] <= din;
  end

  // Stack pointer: clear wins, then push, then pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/rails_sched.sv
// rtl/rails_sched.sv - rails sequencer with op trace; optional RAILS_SCHED_CHECK_EN pattern check
module rails_sched #(
  parameter int MAX_N = rails_pkg::DEF_MAX_N,
  parameter int DW    = rails_pkg::DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] data,
  output logic          busy,
  output logic          op_valid,
  output logic          op_push,
  output logic [DW-1:0] op_car,
  output logic          valid,
  output logic          result
);

  import rails_pkg::*;

  localparam int CW = DW + 1;

  state_t        state_q, state_d;
  logic [DW-1:0] n_q, n_d;
  logic [CW-1:0] k_q, k_d, next_in_q, next_in_d, idx_q, idx_d;
  logic          res_q, res_d;
  logic          busy_d, valid_d, result_d, op_valid_d, op_push_d;
  logic [DW-1:0] op_car_d;
  logic [DW-1:0] seq_q [MAX_N];
  logic          seq_we;
  logic          lifo_push, lifo_pop, lifo_clr, lifo_empty;
  logic [DW-1:0] lifo_top;
  logic [CW-1:0] n_ext;
  logic          match;

  assign n_ext = {1'b0, n_q};
  assign match = !lifo_empty && (lifo_top == seq_q[idx_q[DW-1:0]]);

`ifdef RAILS_SCHED_CHECK_EN
  logic [MAX_N-1:0] seen_q, seen_d;
  logic             bad_q, bad_d, word_bad;
  logic [DW-1:0]    word_idx;

  assign word_idx = data - DW'(1);
  assign word_bad = (data == '0) || (data > n_q) || seen_q[word_idx];

  // Seen mask and sticky illegal flag for the pattern being loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      bad_q  <= bad_d;
    end
  end
`endif

  rails_lifo #(.DEPTH(MAX_N), .W(DW)) u_lifo (
    .clk   (clk),
    .reset (reset),
    .clr   (lifo_clr),
    .push  (lifo_push),
    .pop   (lifo_pop),
    .din   (next_in_q[DW-1:0]),
    .top   (lifo_top),
    .empty (lifo_empty)
  );

  // Departure order buffer, filled in arrival order during LOAD_SEQ.
  always_ff @(posedge clk) begin
    if (seq_we) seq_q[k_q[DW-1:0]] <= data;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      k_q       <= '0;
      next_in_q <= '0;
      idx_q     <= '0;
      res_q     <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      result    <= 1'b0;
      op_valid  <= 1'b0;
      op_push   <= 1'b0;
      op_car    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      k_q       <= k_d;
      next_in_q <= next_in_d;
      idx_q     <= idx_d;
      res_q     <= res_d;
      busy      <= busy_d;
      valid     <= valid_d;
      result    <= result_d;
      op_valid  <= op_valid_d;
      op_push   <= op_push_d;
      op_car    <= op_car_d;
    end
  end

  // Next-state and next-output decisions; RUN makes one shunting decision per cycle.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    next_in_d  = next_in_q;
    idx_d      = idx_q;
    res_d      = res_q;
    busy_d     = busy;
    valid_d    = 1'b0;
    result_d   = result;
    op_valid_d = 1'b0;
    op_push_d  = OP_POP;
    op_car_d   = '0;
    seq_we     = 1'b0;
    lifo_push  = 1'b0;
    lifo_pop   = 1'b0;
    lifo_clr   = 1'b0;
`ifdef RAILS_SCHED_CHECK_EN
    seen_d     = seen_q;
    bad_d      = bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d       = data;
          busy_d    = 1'b1;
          k_d       = '0;
          next_in_d = CW'(1);
          idx_d     = '0;
`ifdef RAILS_SCHED_CHECK_EN
          seen_d    = '0;
          bad_d     = 1'b0;
`endif
          if (data == '0) begin
            res_d   = 1'b1;
            state_d = DONE;
          end else if ({1'b0, data} > CW'(MAX_N)) begin
            res_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = LOAD_SEQ;
          end
        end
      end
      LOAD_SEQ: begin
        if (in_valid) begin
          seq_we = 1'b1;
          k_d    = k_q + CW'(1);
`ifdef RAILS_SCHED_CHECK_EN
          if (word_bad) bad_d = 1'b1;
          else          seen_d = seen_q | (MAX_N'(1) << word_idx);
          if (k_q + CW'(1) == n_ext) begin
            if (bad_q || word_bad) begin
              res_d   = 1'b0;
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end
`else
          if (k_q + CW'(1) == n_ext) state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (match) begin
          lifo_pop   = 1'b1;
          op_valid_d = 1'b1;
          op_push_d  = OP_POP;
          op_car_d   = lifo_top;
          idx_d      = idx_q + CW'(1);
          if (idx_q + CW'(1) == n_ext) begin
            res_d   = 1'b1;
            state_d = DONE;
          end
        end else if (next_in_q <= n_ext) begin
          lifo_push  = 1'b1;
          op_valid_d = 1'b1;
          op_push_d  = OP_PUSH;
          op_car_d   = next_in_q[DW-1:0];
          next_in_d  = next_in_q + CW'(1);
        end else begin
          res_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d  = 1'b1;
        result_d = res_q;
        busy_d   = 1'b0;
        lifo_clr = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
